// File: rtl/cmp_serial_mag_pkg.sv
// cmp_serial_mag_pkg: shared digit width and FSM state encoding for the serial magnitude comparator
package cmp_serial_mag_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cmp2_slice.sv
// cmp2_slice: combinational comparator for one 2-bit digit
//   x, y : digit operands (unsigned)
//   eq/gt/lt : one-hot relation of x to y
module cmp2_slice
    import cmp_serial_mag_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               eq,
    output logic               gt,
    output logic               lt
);

    assign eq = x == y;
    assign gt = x > y;
    assign lt = x < y;

endmodule

// File: rtl/cmp_serial_mag.sv
// cmp_serial_mag: MSB-first serial magnitude comparator, 2 bits per clock, valid/ready in and out
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   a, b                 : WIDTH-bit unsigned operands
//   out_valid/out_ready  : result handshake, result held until accepted
//   a_eq_b/a_gt_b/a_lt_b : one-hot result, kept after acceptance
//   Build option EARLY_EXIT_EN: finish on the first differing digit instead of always D digits.
module cmp_serial_mag
    import cmp_serial_mag_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    localparam int D  = WIDTH / DIGIT_W;
    localparam int CW = $clog2(D + 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic             decided_q, gt_q, lt_q;
    logic             out_valid_q, eq_res_q, gt_res_q, lt_res_q;
    logic             s_eq, s_gt, s_lt;
    logic             decided_d, gt_d, lt_d, finish;

    cmp2_slice u_slice (
        .x  (a_q[WIDTH-1 -: DIGIT_W]),
        .y  (b_q[WIDTH-1 -: DIGIT_W]),
        .eq (s_eq),
        .gt (s_gt),
        .lt (s_lt)
    );

    // Once a digit has differed the verdict is frozen; later digits cannot override it.
    assign decided_d = decided_q | ~s_eq;
    assign gt_d      = decided_q ? gt_q : s_gt;
    assign lt_d      = decided_q ? lt_q : s_lt;

`ifdef EARLY_EXIT_EN
    assign finish = (cnt_q == CW'(1)) | (~decided_q & ~s_eq);
`else
    assign finish = cnt_q == CW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            eq_res_q    <= 1'b0;
            gt_res_q    <= 1'b0;
            lt_res_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    a_q       <= a;
                    b_q       <= b;
                    cnt_q     <= CW'(D);
                    decided_q <= 1'b0;
                    gt_q      <= 1'b0;
                    lt_q      <= 1'b0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    a_q       <= a_q << DIGIT_W;
                    b_q       <= b_q << DIGIT_W;
                    cnt_q     <= cnt_q - CW'(1);
                    decided_q <= decided_d;
                    gt_q      <= gt_d;
                    lt_q      <= lt_d;
                    if (finish) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        eq_res_q    <= ~decided_d;
                        gt_res_q    <= gt_d;
                        lt_res_q    <= lt_d;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = out_valid_q;
    assign a_eq_b    = eq_res_q;
    assign a_gt_b    = gt_res_q;
    assign a_lt_b    = lt_res_q;

endmodule

// File: tb/tb_cmp_serial_mag.sv
// tb_cmp_serial_mag: randomized scoreboard bench for cmp_serial_mag (WIDTH=8)
module tb_cmp_serial_mag;

    localparam int WIDTH = 8;
    localparam int D     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             in_ready, out_valid, a_eq_b, a_gt_b, a_lt_b;

    typedef struct {
        logic eq, gt, lt;
        int   lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, accept_edge = 0;
    logic        prev_ov = 1'b0;
    logic [2:0]  held = '0;

    cmp_serial_mag #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_eq_b    (a_eq_b),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Digits counted MSB-first, 1-based; equal operands walk all D digits.
    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef EARLY_EXIT_EN
        for (int i = 1; i <= D; i++)
            if (((x >> (2 * (D - i))) & 3) != ((y >> (2 * (D - i))) & 3)) return i;
`endif
        return D;
    endfunction

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        bit   ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk) #1;
            ok = in_ready;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
            return;
        end
        e.eq  = x == y;
        e.gt  = x > y;
        e.lt  = x < y;
        e.lat = exp_lat(x, y);
        exp_q.push_back(e);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk) #1;
            ok = exp_q.size() == 0 && in_ready;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: checks latency and result when out_valid rises, stability while it is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) accept_edge = cyc + 1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: out_valid=1 with no outstanding operands");
                end else if (!prev_ov) begin
                    check("latency", cyc - accept_edge, exp_q[0].lat);
                    check("result", {a_eq_b, a_gt_b, a_lt_b}, {exp_q[0].eq, exp_q[0].gt, exp_q[0].lt});
                    check("onehot", $countones({a_eq_b, a_gt_b, a_lt_b}), 1);
                    held = {a_eq_b, a_gt_b, a_lt_b};
                end else begin
                    check("stable", {a_eq_b, a_gt_b, a_lt_b}, held);
                end
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [WIDTH-1:0] vals[4];
        bit ok;
        vals[0] = 8'h00; vals[1] = 8'h55; vals[2] = 8'hAA; vals[3] = 8'hFF;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {a_eq_b, a_gt_b, a_lt_b}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_out_valid", out_valid, 0);
            check("idle_flags", {a_eq_b, a_gt_b, a_lt_b}, 0);
            check("idle_in_ready", in_ready, 1);
        end

        send(8'hA5, 8'hA5);
        send(8'h80, 8'h7F);
        send(8'h12, 8'h13);
        wait_idle();

        // Backpressure with ignored input traffic
        out_ready = 1'b0;
        send(8'h37, 8'h20);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk) #1;
            ok = out_valid;
        end
        check("bp_out_valid_rise", ok, 1);
        repeat (10) begin
            @(posedge clk) #1;
            in_valid = ~in_valid;
            a = 8'hFF;
            b = 8'h00;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk) #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        wait_idle();

        // Reset while comparing
        send(8'h00, 8'hFF);
        repeat (2) @(posedge clk) #1;
        check("mid_run_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_flags", {a_eq_b, a_gt_b, a_lt_b}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h03, 8'h02);
        wait_idle();

        foreach (vals[i])
            foreach (vals[j])
                send(vals[i], vals[j]);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x, y;
            x = WIDTH'($urandom);
            y = (i % 4 == 0) ? x : WIDTH'($urandom);
            send(x, y);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
